// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter.
//   in_*  : request side (valid/ready, operand, amount, mode, carry-in)
//   out_* : response side (valid/ready, data, carry-out, illegal-mode flag)
// master drives requests and out_ready; slave (the shifter) drives the rest.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_op;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_mode;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_amt, in_mode, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_err
  );

  modport slave (
    input  in_valid, in_op, in_amt, in_mode, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_err
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined shift/rotate unit (LSL, LSR, ASR, ROR, optional IMM)
// with ARM-style carry-out and valid/ready flow control on both sides.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : pipelined_barrel_shifter_if.slave (request/response bundle)
// Optional feature macro: SHIFTER_IMM_MODE_EN enables mode 100 (rotated
// immediate); without it mode 100 is reported as illegal.
// Stage 1 registers the request; stage 2 computes and registers the result.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 8
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int LG     = $clog2(WIDTH);
  localparam int SHW    = LG + 1;
  localparam int STAGES = 2;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("WIDTH must be a power of two and at least 8");
  end
  if (IMM_W < 1 || IMM_W > WIDTH) begin : g_bad_imm
    $error("IMM_W must be in 1..WIDTH");
  end

  typedef enum logic [2:0] {
    M_LSL = 3'b000,
    M_LSR = 3'b001,
    M_ASR = 3'b010,
    M_ROR = 3'b011,
    M_IMM = 3'b100
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] op;
    logic [SHW-1:0]   amt;
    logic [2:0]       mode;
    logic             carry;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  req_t            req_in, req_s1;
  rsp_t            rsp_nxt, rsp_s2;

  // Rotate right; a zero amount makes the left term shift by WIDTH, i.e. 0.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input logic [LG-1:0]    r);
    rotr = (x >> r) | (x << (SHW'(WIDTH) - SHW'(r)));
  endfunction

  // Both stages move together whenever the output slot is free or draining.
  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = rsp_s2.data;
  assign bus.out_carry = rsp_s2.carry;
  assign bus.out_err   = rsp_s2.err;

  assign req_in = '{op: bus.in_op, amt: bus.in_amt, mode: bus.in_mode,
                    carry: bus.in_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      req_s1   <= '0;
      rsp_s2   <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) req_s1 <= req_in;
      // Bubbles clear out_valid but leave the last result on the data pins.
      if (vld_pipe[1])  rsp_s2 <= rsp_nxt;
    end
  end

  // One extra bit beside the operand catches the last bit shifted out, so
  // carry falls out of the same shifter. Amounts above WIDTH push every
  // operand bit (and the carry slot) out, giving 0/0 for the logical shifts
  // and sign fill for ASR without separate range compares.
  logic [WIDTH:0]        lsl_ext, lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]      ror_res;
  logic                  amt_zero;

  assign lsl_ext  = {1'b0, req_s1.op} << req_s1.amt;
  assign lsr_ext  = {req_s1.op, 1'b0} >> req_s1.amt;
  assign asr_ext  = $signed({req_s1.op, 1'b0}) >>> req_s1.amt;
  assign ror_res  = rotr(req_s1.op, req_s1.amt[LG-1:0]);
  assign amt_zero = (req_s1.amt == '0);

`ifdef SHIFTER_IMM_MODE_EN
  logic [WIDTH-1:0] imm_op, imm_res;
  assign imm_op  = WIDTH'(req_s1.op[IMM_W-1:0]);
  // Rotate by 2*amt[3:0]; the cast to LG bits is the mod WIDTH.
  assign imm_res = rotr(imm_op, LG'({req_s1.amt[3:0], 1'b0}));
`endif

  always_comb begin
    rsp_nxt       = '0;
    rsp_nxt.carry = req_s1.carry;
    case (req_s1.mode)
      M_LSL, M_LSR, M_ASR, M_ROR: begin
        if (amt_zero) begin
          rsp_nxt.data = req_s1.op;
        end else begin
          case (req_s1.mode)
            M_LSL: begin
              rsp_nxt.data  = lsl_ext[WIDTH-1:0];
              rsp_nxt.carry = lsl_ext[WIDTH];
            end
            M_LSR: begin
              rsp_nxt.data  = lsr_ext[WIDTH:1];
              rsp_nxt.carry = lsr_ext[0];
            end
            M_ASR: begin
              rsp_nxt.data  = asr_ext[WIDTH:1];
              rsp_nxt.carry = asr_ext[0];
            end
            default: begin
              rsp_nxt.data  = ror_res;
              rsp_nxt.carry = ror_res[WIDTH-1];
            end
          endcase
        end
      end
`ifdef SHIFTER_IMM_MODE_EN
      M_IMM: begin
        if (req_s1.amt[3:0] == 4'd0) begin
          rsp_nxt.data = imm_op;
        end else begin
          rsp_nxt.data  = imm_res;
          rsp_nxt.carry = imm_res[WIDTH-1];
        end
      end
`endif
      default: rsp_nxt.err = 1'b1;
    endcase
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, 2-stage pipelined shift/rotate unit; the next-generation shifter for the datapath ALU operand-2 path.
- Supports LSL, LSR, ASR, ROR at full WIDTH, with ARM-style carry-out.
- Uses a valid/ready handshake on input and output, so it can sit between decode and ALU stages under back-pressure.

Parameters:
WIDTH, 32, data path width in bits; must be a power of two, at least 8.
IMM_W, 8, immediate field width used by the IMM mode.
SHW, $clog2(WIDTH)+1, shift-amount width; derived, not to be overridden.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input transaction valid.
in_ready  out  1  unit can accept an input this cycle.
in_op  in  WIDTH  operand.
in_amt  in  SHW  shift/rotate amount.
in_mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 IMM, 101-111 illegal.
in_carry  in  1  current C flag, passed through when amount is 0.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  shifted result.
out_carry  out  1  shifter carry-out.
out_err  out  1  illegal mode flag for this result.

Behaviour:
- Reset (rst_n low, asynchronous): clear both stage valids. out_valid=0, out_data=0, out_carry=0, out_err=0. in_ready is 1 while reset is held and on the first cycle after release. In-flight items are discarded even if reset is asserted mid-stream.
- Pipe enable: en = !out_valid || out_ready. Both stages advance only when en=1.
  - in_ready = en, which is combinational from out_ready and out_valid.
  - An input is accepted when in_valid && in_ready.
- Stage 1: registers op, amt, mode and carry, plus its valid bit.
  - The coarse shift (amount bits above log2(WIDTH)/2) may also be done here; the split is free, provided latency stays as specified.
- Stage 2: computes the final result and registers out_data, out_carry, out_err and out_valid.
- Latency and throughput: with no stall, an item accepted at edge N appears with out_valid=1 after edge N+2. Throughput is 1 per cycle.
- Stalls: while out_valid && !out_ready, all stage registers and outputs hold. At most 2 items are in flight. There is no loss, no duplication, and ordering is strict.
- When a stage bubble advances, the outputs take out_valid=0. out_data, out_carry and out_err hold their last values.
- Amount 0, any legal mode: data = op, carry = in_carry.
- LSL, 0<amt<WIDTH: data = op<<amt, carry = op[WIDTH-amt]. amt=WIDTH: data 0, carry op[0]. amt>WIDTH: data 0, carry 0.
- LSR, 0<amt<WIDTH: data = op>>amt, carry = op[amt-1]. amt=WIDTH: data 0, carry op[WIDTH-1]. amt>WIDTH: data 0, carry 0.
- ASR, 0<amt<WIDTH: sign fill, carry = op[amt-1]. amt>=WIDTH: data is all copies of op[WIDTH-1], carry = op[WIDTH-1].
- ROR, amt nonzero: the rotate amount is amt mod WIDTH; carry = data[WIDTH-1]. If amt is nonzero but a multiple of WIDTH, data = op and carry = op[WIDTH-1].
- Illegal mode (101-111, or 100 with the optional feature absent): data 0, carry = in_carry, out_err=1. Handshake and latency are unchanged.
- out_err=0 for all legal modes.

Optional Feature:
Macro: SHIFTER_IMM_MODE_EN
- Defined, IMM mode (100) is legal:
  - operand = zero-extended op[IMM_W-1:0]; rotate right by (2*amt[3:0]) mod WIDTH.
  - amt[3:0]=0: data is the zero-extended immediate, carry = in_carry.
  - Otherwise carry = data[WIDTH-1].
  - amt[SHW-1:4] is ignored.
- Undefined, mode 100 is illegal (out_err=1, data 0). No IMM logic is synthesised.

Test Plan:
- Reset mid-stream: two items accepted, then rst_n pulsed low between clock edges -> out_valid=0, out_data=0, out_carry=0 immediately; neither item ever emerges; in_ready=1 after release.
- LSL op=0x8000_0001 amt=1 cin=0, out_ready=1 -> two edges later out_data=0x0000_0002, out_carry=1, out_err=0. Same op with amt=32 -> 0x0000_0000, carry 1. Same op with amt=33 -> 0x0000_0000, carry 0.
- ASR op=0x8000_00F0 amt=4 -> 0xF800_000F, carry 0. Same op with amt=40 -> 0xFFFF_FFFF, carry 1. LSR op=0x8000_00F0 amt=0 cin=1 -> 0x8000_00F0, carry 1.
- ROR op=0x0000_00F1 amt=4 -> 0x1000_000F, carry 0. amt=36 -> same result. amt=32 -> 0x0000_00F1, carry 0.
- Back-pressure: out_ready=0 while 3 items (ROR op=0xF1 with amt 1, 2, 3) are offered back-to-back.
  - in_ready drops once 2 items are held; the third waits.
  - After out_ready=1: results 0x8000_0078, 0x4000_003C, 0x2000_001E appear on consecutive cycles, in order, with no gaps.
- IMM with macro defined: op=0x0000_00F1 amt=4 -> 0xF100_0000, carry 1. Same with macro undefined -> out_data=0, out_err=1, out_carry=in_carry. mode=111 -> out_err=1 in both builds.
